sram_controller: RTL and testbench
==================================

# sram_controller

Memory-stage controller that sequences 32-bit data-memory accesses from the pipeline onto a 16-bit-wide, multi-cycle external SRAM. It sits between the MEM stage and the SRAM. The MEM stage supplies `memRead`/`memWrite` as produced by the decode control unit. This block splits each word into two half-word SRAM cycles with programmable wait states. It holds `ready` low to freeze the pipeline until the access completes.

## Interface
Parameters:
- `WAIT_CYCLES`, 5: clock cycles per half-word SRAM access; legal range ≥1.
- `ADDR_BASE`, 1024: byte address that maps to SRAM word 0.

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `memRead`  in  1  load request from MEM stage.
- `memWrite`  in  1  store request from MEM stage.
- `address`  in  32  byte address, i.e. the ALU result.
- `writeData`  in  32  store data.
- `readData`  out  32  load result; holds its value until the next read completes.
- `ready`  out  1  high means the pipeline may advance; the pipeline freezes on `~ready`.
- `sramAddr`  out  18  SRAM half-word address.
- `sramWrData`  out  16  SRAM write data.
- `sramRdData`  in  16  SRAM read data.
- `sramWeN`  out  1  SRAM write enable, active-low.

## Operation
- Word index `wa` = ((`address` − `ADDR_BASE`) mod 2^32)[18:2]. `address[1:0]` is ignored.
- Half-word addresses:
  - low half: `sramAddr` = {`wa`, 1'b0}
  - high half: `sramAddr` = {`wa`, 1'b1}
- FSM states: IDLE, LOW, HIGH, DONE.
- IDLE:
  - If `memRead | memWrite`: latch `wa`, `writeData` and the op, load the counter with `WAIT_CYCLES`−1, then go to LOW.
  - If both `memRead` and `memWrite` are high, the op is a write.
  - With no request, stay in IDLE.
- LOW:
  - Drive the low-half address.
  - For a write, drive `sramWrData` = wd[15:0] and `sramWeN`=0.
  - Decrement the counter each cycle.
  - On the edge where the counter is 0: for a read, capture `sramRdData` into a low-half holding register. Then reload the counter and go to HIGH.
- HIGH:
  - Same as LOW, using the high-half address and wd[31:16].
  - On the counter-0 edge: for a read, `readData` ← {`sramRdData`, low-half holding register}.
  - Then go to DONE.
- DONE: `ready`=1 for one cycle, then go to IDLE unconditionally. The request still present in this cycle is not restarted.
- `ready` is combinational:
  - 1 in DONE;
  - 1 in IDLE with no request;
  - 0 otherwise, including the IDLE cycle in which a request first appears.
- `sramAddr`, `sramWrData` and `sramWeN` are decoded from the state and the latched registers only, never directly from pipeline inputs.
  - In IDLE and DONE: `sramWeN`=1, and `sramAddr`/`sramWrData` hold their last values.
  - In a read: `sramWeN` stays 1.
- Reset values: state IDLE, `readData`=0, `sramAddr`=0, `sramWrData`=0, `sramWeN`=1, counter 0. `ready` is therefore 1 whenever there is no request.
- Reset asserted mid-access: immediate return to IDLE and `sramWeN`=1 asynchronously. No partial `readData` update, and no further SRAM cycle.

## Timing
- Request first seen in IDLE at cycle 0:
  - LOW occupies cycles 1..W;
  - HIGH occupies cycles W+1..2W;
  - DONE is cycle 2W+1.
  - Here W=`WAIT_CYCLES`.
- Freeze length is 2W+1 cycles, with `ready` low from cycle 0 through cycle 2W. The pipeline advances on the rising edge that ends cycle 2W+1.
- `readData` becomes valid at the start of DONE and is stable while `ready`=1.
- SRAM read data is sampled at the end of the last wait cycle of each phase, so the SRAM must produce data within W cycles.
- Back-to-back requests: the request following DONE is seen in IDLE at cycle 2W+2. There is no lost or merged access.
- With no request, `ready` stays 1 continuously with zero added latency.

## Test plan
- Reset and idle: hold `rst_n`=0, then release with no request.
  - During reset: `ready`=1, `sramWeN`=1, `readData`=0.
  - After release: `ready` stays 1 for 20 cycles.
- Write, W=5: `memWrite`=1, `address`=1024, `writeData`=0xDEADBEEF.
  - Cycles 1–5: `sramAddr`=0, `sramWrData`=0xBEEF, `sramWeN`=0.
  - Cycles 6–10: `sramAddr`=1, `sramWrData`=0xDEAD, `sramWeN`=0.
  - `ready` is 0 in cycles 0–10 and 1 in cycle 11.
- Read-back, W=5: with an SRAM model, `memRead`=1, `address`=1024 after the write above.
  - `readData`=0xDEADBEEF at cycle 11; `sramWeN` stays 1 throughout.
- Back-to-back, W=1: write 0x12345678 to 1028 immediately followed by a read of 1028.
  - Write: `sramAddr` 2 then 3.
  - `ready` pulses at cycle 3 and again at cycle 7.
  - `readData`=0x12345678.
- Reset mid-access: assert `rst_n`=0 in cycle 3 of a write.
  - `sramWeN`=1 immediately; state returns to IDLE.
  - `readData` is unchanged, and no SRAM cycle occurs after release.
- Simultaneous requests: `memRead`=`memWrite`=1 with `writeData`=0x0000FFFF.
  - The op is performed as a write: `sramWeN`=0 in both phases.
  - `readData` is unchanged.

Source files
------------

// File: rtl/sram_controller.sv
// rtl/sram_controller.sv - 32-bit MEM-stage access sequencer onto a 16-bit multi-cycle SRAM
module sram_controller #(
  parameter int WAIT_CYCLES = 5,
  parameter int ADDR_BASE   = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        memRead,
  input  logic        memWrite,
  input  logic [31:0] address,
  input  logic [31:0] writeData,
  output logic [31:0] readData,
  output logic        ready,
  output logic [17:0] sramAddr,
  output logic [15:0] sramWrData,
  input  logic [15:0] sramRdData,
  output logic        sramWeN
);

  localparam int CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(WAIT_CYCLES - 1);
  localparam logic [31:0] BASE = 32'(ADDR_BASE);

  typedef enum logic [1:0] {S_IDLE, S_LOW, S_HIGH, S_DONE} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [16:0]   wa_q, wa_d;
  logic [31:0]   wd_q, wd_d;
  logic          wr_q, wr_d;
  logic [15:0]   lo_q, lo_d;
  logic [31:0]   rd_data_q, rd_data_d;
  logic [17:0]   addr_q, addr_d;
  logic [15:0]   wrdata_q, wrdata_d;

  // Only bits [18:2] of the rebased address select a word; the rest wrap away.
  logic [18:0] offset;
  logic        unused_addr_bits;
  assign offset           = address[18:0] - BASE[18:0];
  assign unused_addr_bits = ^{address[31:19], offset[1:0]};

  // Next-state, latch and SRAM pin decode; pins depend only on state and latched values.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    wa_d       = wa_q;
    wd_d       = wd_q;
    wr_d       = wr_q;
    lo_d       = lo_q;
    rd_data_d  = rd_data_q;
    sramAddr   = addr_q;
    sramWrData = wrdata_q;
    sramWeN    = 1'b1;
    ready      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (memRead | memWrite) begin
          wa_d    = offset[18:2];
          wd_d    = writeData;
          wr_d    = memWrite;
          cnt_d   = CNT_LOAD;
          state_d = S_LOW;
        end else begin
          ready = 1'b1;
        end
      end
      S_LOW: begin
        sramAddr = {wa_q, 1'b0};
        if (wr_q) begin
          sramWrData = wd_q[15:0];
          sramWeN    = 1'b0;
        end
        if (cnt_q == '0) begin
          if (!wr_q) lo_d = sramRdData;
          cnt_d   = CNT_LOAD;
          state_d = S_HIGH;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_HIGH: begin
        sramAddr = {wa_q, 1'b1};
        if (wr_q) begin
          sramWrData = wd_q[31:16];
          sramWeN    = 1'b0;
        end
        if (cnt_q == '0) begin
          if (!wr_q) rd_data_d = {sramRdData, lo_q};
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: begin
        ready   = 1'b1;
        state_d = S_IDLE;
      end
    endcase

    addr_d   = sramAddr;
    wrdata_d = sramWrData;
  end

  assign readData = rd_data_q;

  // State and datapath registers; reset abandons any access in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      wa_q      <= '0;
      wd_q      <= '0;
      wr_q      <= 1'b0;
      lo_q      <= '0;
      rd_data_q <= '0;
      addr_q    <= '0;
      wrdata_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      wa_q      <= wa_d;
      wd_q      <= wd_d;
      wr_q      <= wr_d;
      lo_q      <= lo_d;
      rd_data_q <= rd_data_d;
      addr_q    <= addr_d;
      wrdata_q  <= wrdata_d;
    end
  end

endmodule

// File: tb/tb_sram_controller.sv
// tb/tb_sram_controller.sv - directed and random checks of sram_controller at W=5 and W=1
module tb_sram_controller;

  logic        clk = 1'b0;
  logic        rst_n        [2];
  logic        mem_read     [2];
  logic        mem_write    [2];
  logic [31:0] address      [2];
  logic [31:0] write_data   [2];
  logic [31:0] read_data    [2];
  logic        ready        [2];
  logic [17:0] sram_addr    [2];
  logic [15:0] sram_wr_data [2];
  logic [15:0] sram_rd_data [2];
  logic        sram_we_n    [2];

  logic [15:0] sram_mem [2][256];
  logic [31:0] ref_mem  [2][64];
  logic        written  [2][64];
  logic [31:0] last_rd  [2];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    sram_controller #(.WAIT_CYCLES(g == 0 ? 5 : 1), .ADDR_BASE(1024)) u_dut (
      .clk        (clk),
      .rst_n      (rst_n[g]),
      .memRead    (mem_read[g]),
      .memWrite   (mem_write[g]),
      .address    (address[g]),
      .writeData  (write_data[g]),
      .readData   (read_data[g]),
      .ready      (ready[g]),
      .sramAddr   (sram_addr[g]),
      .sramWrData (sram_wr_data[g]),
      .sramRdData (sram_rd_data[g]),
      .sramWeN    (sram_we_n[g])
    );
    assign sram_rd_data[g] = sram_mem[g][sram_addr[g][7:0]];
  end

  // SRAM behaviour: a low write-enable stores the driven half-word at the edge.
  always @(posedge clk) begin
    for (int k = 0; k < 2; k++)
      if (sram_we_n[k] === 1'b0) sram_mem[k][sram_addr[k][7:0]] <= sram_wr_data[k];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One MEM-stage access; entered just after a rising edge, returns just after one.
  task automatic access(input int k, input logic rd, input logic wr,
                        input logic [31:0] addr, input logic [31:0] wd);
    int          w;
    int          idx;
    logic        is_wr;
    logic [31:0] off;
    logic [31:0] exp_rd;
    logic        hi;
    w      = (k == 0) ? 5 : 1;
    off    = addr - 32'd1024;
    idx    = int'(off[18:2]);
    is_wr  = wr;
    exp_rd = is_wr ? last_rd[k] : ref_mem[k][idx];
    mem_read[k]   = rd;
    mem_write[k]  = wr;
    address[k]    = addr;
    write_data[k] = wd;
    @(negedge clk);
    chk($sformatf("k%0d_c0_ready", k), 32'(ready[k]), 32'd0);
    for (int c = 1; c <= 2 * w + 1; c++) begin
      @(negedge clk);
      if (c <= 2 * w) begin
        hi = (c > w);
        chk($sformatf("k%0d_c%0d_ready", k, c), 32'(ready[k]), 32'd0);
        chk($sformatf("k%0d_c%0d_addr", k, c), 32'(sram_addr[k]), 32'(idx * 2 + int'(hi)));
        chk($sformatf("k%0d_c%0d_wen", k, c), 32'(sram_we_n[k]), is_wr ? 32'd0 : 32'd1);
        if (is_wr)
          chk($sformatf("k%0d_c%0d_wrdata", k, c), 32'(sram_wr_data[k]),
              hi ? 32'(wd[31:16]) : 32'(wd[15:0]));
      end else begin
        chk($sformatf("k%0d_done_ready", k), 32'(ready[k]), 32'd1);
        chk($sformatf("k%0d_done_rdata", k), read_data[k], exp_rd);
      end
    end
    last_rd[k] = exp_rd;
    if (is_wr) begin
      ref_mem[k][idx] = wd;
      written[k][idx] = 1'b1;
    end
    @(posedge clk);
    #1;
    mem_read[k]  = 1'b0;
    mem_write[k] = 1'b0;
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      rst_n[k] = 1'b0; mem_read[k] = 1'b0; mem_write[k] = 1'b0;
      address[k] = '0; write_data[k] = '0; last_rd[k] = '0;
      for (int i = 0; i < 64; i++) begin
        ref_mem[k][i] = '0; written[k][i] = 1'b0;
      end
    end

    // reset and idle
    repeat (3) @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("k%0d_rst_ready", k), 32'(ready[k]), 32'd1);
      chk($sformatf("k%0d_rst_wen", k), 32'(sram_we_n[k]), 32'd1);
      chk($sformatf("k%0d_rst_rdata", k), read_data[k], 32'd0);
      rst_n[k] = 1'b1;
    end
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("idle_ready0", 32'(ready[0]), 32'd1);
      chk("idle_ready1", 32'(ready[1]), 32'd1);
    end

    // reset during cycle 3 of a write
    @(posedge clk); #1;
    mem_write[0] = 1'b1; address[0] = 32'd1032; write_data[0] = 32'hCAFEF00D;
    repeat (4) @(negedge clk);
    chk("mid_wen_before", 32'(sram_we_n[0]), 32'd0);
    rst_n[0] = 1'b0;
    #1;
    chk("mid_wen_async", 32'(sram_we_n[0]), 32'd1);
    chk("mid_rdata", read_data[0], last_rd[0]);
    mem_write[0] = 1'b0;
    #1;
    chk("mid_ready", 32'(ready[0]), 32'd1);
    @(negedge clk);
    rst_n[0] = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      chk("post_rst_wen", 32'(sram_we_n[0]), 32'd1);
      chk("post_rst_ready", 32'(ready[0]), 32'd1);
    end

    // directed write / read-back at W=5
    @(posedge clk); #1;
    access(0, 1'b0, 1'b1, 32'd1024, 32'hDEADBEEF);
    access(0, 1'b1, 1'b0, 32'd1024, 32'h0);
    chk("w5_readback", read_data[0], 32'hDEADBEEF);

    // back-to-back at W=1
    access(1, 1'b0, 1'b1, 32'd1028, 32'h12345678);
    access(1, 1'b1, 1'b0, 32'd1028, 32'h0);
    chk("w1_readback", read_data[1], 32'h12345678);

    // simultaneous read and write requests behave as a write
    access(1, 1'b1, 1'b1, 32'd1036, 32'h0000FFFF);
    chk("simul_rdata_kept", read_data[1], 32'h12345678);
    access(1, 1'b1, 1'b0, 32'd1036, 32'h0);
    chk("simul_readback", read_data[1], 32'h0000FFFF);

    // random traffic with random idle gaps
    for (int i = 0; i < 40; i++) begin
      int          k;
      int          idx;
      logic        do_wr;
      logic        do_rd;
      logic [31:0] a;
      k     = int'($urandom_range(0, 1));
      idx   = int'($urandom_range(0, 63));
      do_wr = 1'($urandom_range(0, 1));
      if (!written[k][idx]) do_wr = 1'b1;
      do_rd = do_wr ? 1'($urandom_range(0, 1)) : 1'b1;
      a     = 32'd1024 + 32'(idx * 4) + 32'($urandom_range(0, 3));
      access(k, do_rd, do_wr, a, $urandom);
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #1;
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
